// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding,
// fault cause codes and the default reset PC.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [3:0]  CAUSE_MISALIGNED = 4'd0;
    localparam logic [3:0]  CAUSE_ACCESS     = 4'd1;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two FIFO with flush. The head entry is read straight
// from the storage registers so decode never sees the memory path.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, redirect/trap handling,
// fault detection and the fetch buffer feeding decode.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = 32,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault_valid,
    output logic [31:0] fault_pc,
    output logic [3:0]  fault_cause
);

    // Decode handshake: an entry transfers on a cycle where if_valid and
    // if_ready are both high; if_valid never depends on if_ready.

    localparam int          LW          = $clog2(BUF_DEPTH) + 1;
    localparam logic [31:0] PC_LIMIT    = 32'(4 * IMEM_WORDS);
    localparam logic [LW-1:0] ALMOST    = LW'(BUF_DEPTH - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_valid_d;
    logic [31:0]  fault_pc_d;
    logic [3:0]   fault_cause_d;
    logic [31:0]  target;
    logic         push, pop, flush;
    logic         fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [63:0]  head;

    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(64)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({pc_q, imem_instr}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign imem_addr = pc_q;
    assign if_valid  = !fifo_empty;
    assign if_pc     = head[63:32];
    assign if_instr  = head[31:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fault_valid_d = fault_valid;
        fault_pc_d    = fault_pc;
        fault_cause_d = fault_cause;
        target        = '0;
        push          = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;

        // HALT ignores redirects; only a trap can leave it.
        if (trap_valid || (redirect_valid && state_q != ST_HALT)) begin
            target = trap_valid ? trap_pc : redirect_pc;
            flush  = 1'b1;
            pc_d   = target;
            if (target[1:0] != 2'b00) begin
                state_d       = ST_HALT;
                fault_valid_d = 1'b1;
                fault_pc_d    = target;
                fault_cause_d = CAUSE_MISALIGNED;
            end else begin
                state_d       = ST_FETCH;
                fault_valid_d = 1'b0;
                fault_pc_d    = '0;
                fault_cause_d = '0;
            end
        end else begin
            pop = !fifo_empty && if_ready;
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (!fifo_full || pop) begin
                        if (pc_q >= PC_LIMIT) begin
                            state_d       = ST_HALT;
                            fault_valid_d = 1'b1;
                            fault_pc_d    = pc_q;
                            fault_cause_d = CAUSE_ACCESS;
                        end else begin
                            push = 1'b1;
                            pc_d = pc_q + 32'd4;
                            if (!pop && fifo_level == ALMOST) begin
                                state_d = ST_STALL;
                            end
                        end
                    end else begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: if (pop) state_d = ST_FETCH;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            fault_valid <= 1'b0;
            fault_pc    <= '0;
            fault_cause <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fault_valid <= fault_valid_d;
            fault_pc    <= fault_pc_d;
            fault_cause <= fault_cause_d;
        end
    end

endmodule
